nasti_lite_reader: RTL and testbench

- Downstream stage of the NASTI read-width narrower. Takes full NASTI read bursts (INCR) on its slave-facing input and replays each beat as a single NASTI-Lite read. Collects the Lite responses and returns them as one NASTI R burst carrying the original id and an r_last flag.
- Sits between the narrower's slave port and Lite-only peripherals.

---
 rtl/nasti_lite_reader_pkg.sv | 33 +++
 rtl/nasti_lite_reader_buf.sv | 75 +++++++
 rtl/nasti_lite_reader.sv | 169 ++++++++++++++++
 tb/tb_nasti_lite_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_lite_reader_pkg.sv
// Shared types and encodings for the NASTI burst to NASTI-Lite read converter.
// The request struct holds the fixed-width AR fields; id/addr/user are parameterised and kept alongside.
package nasti_lite_reader_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One bit wider than len so a 256-beat burst can count past 255 without wrapping.
    localparam int CNT_WIDTH = 9;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } reader_state_t;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } nasti_req_t;

    function automatic logic [CNT_WIDTH-1:0] in_flight(input logic [CNT_WIDTH-1:0] issued,
                                                       input logic [CNT_WIDTH-1:0] retired);
        return issued - retired;
    endfunction

endpackage

// File: rtl/nasti_lite_reader_buf.sv
// First-word-fall-through response FIFO; head, empty and full all come straight from flops.
// A push and a pop in the same cycle are both honoured, even when full.
module nasti_lite_reader_buf #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full_q));

endmodule

// File: rtl/nasti_lite_reader.sv
// Replays each beat of a NASTI INCR read burst as a single Lite read and reassembles the
// Lite responses into one NASTI R burst; outstanding Lite reads are capped at the buffer depth.
module nasti_lite_reader
    import nasti_lite_reader_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   nasti_ar_id,
    input  logic [ADDR_WIDTH-1:0] nasti_ar_addr,
    input  logic [7:0]            nasti_ar_len,
    input  logic [2:0]            nasti_ar_size,
    input  logic [1:0]            nasti_ar_burst,
    input  logic                  nasti_ar_lock,
    input  logic [3:0]            nasti_ar_cache,
    input  logic [2:0]            nasti_ar_prot,
    input  logic [3:0]            nasti_ar_qos,
    input  logic [3:0]            nasti_ar_region,
    input  logic [USER_WIDTH-1:0] nasti_ar_user,
    input  logic                  nasti_ar_valid,
    output logic                  nasti_ar_ready,
    output logic [ID_WIDTH-1:0]   nasti_r_id,
    output logic [DATA_WIDTH-1:0] nasti_r_data,
    output logic [1:0]            nasti_r_resp,
    output logic                  nasti_r_last,
    output logic [USER_WIDTH-1:0] nasti_r_user,
    output logic                  nasti_r_valid,
    input  logic                  nasti_r_ready,
    output logic [ADDR_WIDTH-1:0] lite_ar_addr,
    output logic [2:0]            lite_ar_prot,
    output logic [3:0]            lite_ar_qos,
    output logic [3:0]            lite_ar_region,
    output logic [USER_WIDTH-1:0] lite_ar_user,
    output logic                  lite_ar_valid,
    input  logic                  lite_ar_ready,
    input  logic [DATA_WIDTH-1:0] lite_r_data,
    input  logic [1:0]            lite_r_resp,
    input  logic [USER_WIDTH-1:0] lite_r_user,
    input  logic                  lite_r_valid,
    output logic                  lite_r_ready
);
    localparam int BUF_WIDTH   = DATA_WIDTH + 2 + USER_WIDTH;
    localparam int LIMIT_WIDTH = CNT_WIDTH + 1;
    localparam logic [LIMIT_WIDTH-1:0] OUTSTANDING_MAX = LIMIT_WIDTH'(BUF_DEPTH);

    reader_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]   ar_cnt_q, ar_cnt_d, r_cnt_q, r_cnt_d;
    nasti_req_t             req_q, req_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [USER_WIDTH-1:0]  user_q, user_d;

    logic [CNT_WIDTH-1:0]   outstanding, last_idx;
    logic                   in_burst, lite_ar_fire, lite_r_fire, nasti_r_fire;
    logic                   buf_empty, buf_full;
    logic [BUF_WIDTH-1:0]   buf_head;
    logic                   unused_ok;

    assign in_burst    = (state_q == S_BURST);
    assign outstanding = in_flight(ar_cnt_q, r_cnt_q);
    assign last_idx    = {1'b0, req_q.len};

    // ar_cnt only moves on a handshake, so a pending address is held stable until accepted.
    assign lite_ar_valid  = in_burst && (ar_cnt_q <= last_idx)
                            && ({1'b0, outstanding} < OUTSTANDING_MAX);
    assign lite_ar_addr   = addr_q + (ADDR_WIDTH'(ar_cnt_q) << req_q.size);
    assign lite_ar_prot   = req_q.prot;
    assign lite_ar_qos    = req_q.qos;
    assign lite_ar_region = req_q.region;
    assign lite_ar_user   = user_q;
    assign lite_ar_fire   = lite_ar_valid && lite_ar_ready;

    assign lite_r_ready = in_burst;
    assign lite_r_fire  = lite_r_valid && lite_r_ready;

    assign nasti_r_valid = !buf_empty;
    assign nasti_r_fire  = nasti_r_valid && nasti_r_ready;
    assign nasti_r_id    = id_q;
    assign nasti_r_last  = (r_cnt_q == last_idx);
    assign {nasti_r_data, nasti_r_resp, nasti_r_user} = buf_head;

    // Lock/cache have no Lite counterpart; burst is only checked at accept.
    assign unused_ok = ^{req_q.lock, req_q.cache, req_q.burst, buf_full};

    always_comb begin
        state_d        = state_q;
        ar_cnt_d       = ar_cnt_q;
        r_cnt_d        = r_cnt_q;
        req_d          = req_q;
        id_d           = id_q;
        addr_d         = addr_q;
        user_d         = user_q;
        nasti_ar_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                nasti_ar_ready = 1'b1;
                if (nasti_ar_valid) begin
                    req_d.len    = nasti_ar_len;
                    req_d.size   = nasti_ar_size;
                    req_d.burst  = nasti_ar_burst;
                    req_d.lock   = nasti_ar_lock;
                    req_d.cache  = nasti_ar_cache;
                    req_d.prot   = nasti_ar_prot;
                    req_d.qos    = nasti_ar_qos;
                    req_d.region = nasti_ar_region;
                    id_d         = nasti_ar_id;
                    addr_d       = nasti_ar_addr;
                    user_d       = nasti_ar_user;
                    ar_cnt_d     = '0;
                    r_cnt_d      = '0;
                    state_d      = S_BURST;
                end
            end
            S_BURST: begin
                if (lite_ar_fire) ar_cnt_d = ar_cnt_q + 1'b1;
                if (nasti_r_fire) begin
                    r_cnt_d = r_cnt_q + 1'b1;
                    if (nasti_r_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ar_cnt_q <= '0;
            r_cnt_q  <= '0;
            req_q    <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            user_q   <= '0;
        end else begin
            state_q  <= state_d;
            ar_cnt_q <= ar_cnt_d;
            r_cnt_q  <= r_cnt_d;
            req_q    <= req_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            user_q   <= user_d;
        end
    end

    nasti_lite_reader_buf #(
        .WIDTH (BUF_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (lite_r_fire),
        .push_data ({lite_r_data, lite_r_resp, lite_r_user}),
        .pop       (nasti_r_fire),
        .head_data (buf_head),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    a_burst_incr: assert property (@(posedge clk) disable iff (!rstn)
        (nasti_ar_valid && nasti_ar_ready) |-> (nasti_ar_burst == BURST_INCR));
    a_no_lite_r_idle: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == S_IDLE) |-> !lite_r_valid);

endmodule

// File: tb/tb_nasti_lite_reader.sv
// Directed bench: a Lite slave model answers with address-derived data, tasks drive bursts and check beats.
module tb_nasti_lite_reader;
    import nasti_lite_reader_pkg::*;

    localparam int ID_W = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int UW   = 1;
    localparam int BD   = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic [ID_W-1:0] nasti_ar_id = '0;
    logic [AW-1:0]   nasti_ar_addr = '0;
    logic [7:0]      nasti_ar_len = '0;
    logic [2:0]      nasti_ar_size = '0;
    logic [1:0]      nasti_ar_burst = BURST_INCR;
    logic            nasti_ar_lock = 1'b0;
    logic [3:0]      nasti_ar_cache = '0;
    logic [2:0]      nasti_ar_prot = '0;
    logic [3:0]      nasti_ar_qos = '0;
    logic [3:0]      nasti_ar_region = '0;
    logic [UW-1:0]   nasti_ar_user = '0;
    logic            nasti_ar_valid = 1'b0;
    logic            nasti_ar_ready;
    logic [ID_W-1:0] nasti_r_id;
    logic [DW-1:0]   nasti_r_data;
    logic [1:0]      nasti_r_resp;
    logic            nasti_r_last;
    logic [UW-1:0]   nasti_r_user;
    logic            nasti_r_valid;
    logic            nasti_r_ready = 1'b0;
    logic [AW-1:0]   lite_ar_addr;
    logic [2:0]      lite_ar_prot;
    logic [3:0]      lite_ar_qos;
    logic [3:0]      lite_ar_region;
    logic [UW-1:0]   lite_ar_user;
    logic            lite_ar_valid;
    logic            lite_ar_ready = 1'b0;
    logic [DW-1:0]   lite_r_data = '0;
    logic [1:0]      lite_r_resp = '0;
    logic [UW-1:0]   lite_r_user = '0;
    logic            lite_r_valid = 1'b0;
    logic            lite_r_ready;

    always #5 clk = ~clk;

    nasti_lite_reader #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rstn(rstn),
        .nasti_ar_id(nasti_ar_id), .nasti_ar_addr(nasti_ar_addr), .nasti_ar_len(nasti_ar_len),
        .nasti_ar_size(nasti_ar_size), .nasti_ar_burst(nasti_ar_burst), .nasti_ar_lock(nasti_ar_lock),
        .nasti_ar_cache(nasti_ar_cache), .nasti_ar_prot(nasti_ar_prot), .nasti_ar_qos(nasti_ar_qos),
        .nasti_ar_region(nasti_ar_region), .nasti_ar_user(nasti_ar_user),
        .nasti_ar_valid(nasti_ar_valid), .nasti_ar_ready(nasti_ar_ready),
        .nasti_r_id(nasti_r_id), .nasti_r_data(nasti_r_data), .nasti_r_resp(nasti_r_resp),
        .nasti_r_last(nasti_r_last), .nasti_r_user(nasti_r_user),
        .nasti_r_valid(nasti_r_valid), .nasti_r_ready(nasti_r_ready),
        .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot), .lite_ar_qos(lite_ar_qos),
        .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
        .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
        .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp), .lite_r_user(lite_r_user),
        .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] ar_log[$];
    bit            slave_rand = 1'b0;
    bit            err_en = 1'b0;
    logic [AW-1:0] err_addr = '0;
    bit            r_hold = 1'b0;

    logic [ID_W-1:0] cur_id;
    logic [AW-1:0]   cur_addr;
    logic [7:0]      cur_len;
    logic [2:0]      cur_size;

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction

    function automatic logic [1:0] mk_resp(input logic [AW-1:0] a);
        return (err_en && a == err_addr) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [UW-1:0] mk_user(input logic [AW-1:0] a);
        return UW'(a[2]);
    endfunction

    // Lite slave: everything decided at the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            pend_q.delete();
            lite_ar_ready = 1'b0;
            lite_r_valid  = 1'b0;
            r_hold        = 1'b0;
        end else begin
            lite_ar_ready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!r_hold) begin
                if (pend_q.size() > 0 && (!slave_rand || $urandom_range(0, 1) == 1)) begin
                    lite_r_valid = 1'b1;
                    lite_r_data  = mk_data(pend_q[0]);
                    lite_r_resp  = mk_resp(pend_q[0]);
                    lite_r_user  = mk_user(pend_q[0]);
                end else begin
                    lite_r_valid = 1'b0;
                end
            end
            r_hold = 1'b0;
            if (lite_r_valid) begin
                if (lite_r_ready) void'(pend_q.pop_front());
                else r_hold = 1'b1;
            end
            if (lite_ar_valid && lite_ar_ready) begin
                pend_q.push_back(lite_ar_addr);
                ar_log.push_back(lite_ar_addr);
            end
        end
    end

    task automatic start_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [2:0] size);
        int cyc;
        @(negedge clk);
        cur_id = id; cur_addr = addr; cur_len = len; cur_size = size;
        ar_log.delete();
        nasti_ar_id = id; nasti_ar_addr = addr; nasti_ar_len = len; nasti_ar_size = size;
        nasti_ar_burst = BURST_INCR;
        nasti_ar_valid = 1'b1;
        cyc = 0;
        while (!nasti_ar_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (nasti_ar_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_accept: ar_ready=%b required 1", nasti_ar_ready);
        end
        @(negedge clk);
        nasti_ar_valid = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: random ready.
    task automatic collect(input int nbeats, input int mode);
        int i, cyc;
        logic [AW-1:0] a;
        logic [ID_W+DW+2+UW:0] got, exp;
        i = 0;
        cyc = 0;
        while (i < nbeats && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            nasti_r_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (nasti_r_valid && nasti_r_ready) begin
                a   = cur_addr + (AW'(i) << cur_size);
                exp = {cur_id, mk_data(a), mk_resp(a), mk_user(a), (i == int'(cur_len))};
                got = {nasti_r_id, nasti_r_data, nasti_r_resp, nasti_r_user, nasti_r_last};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL r_beat[%0d]: {id,data,resp,user,last}=%h required %h", i, got, exp);
                end
                i++;
            end
        end
        n_cmp++;
        if (i != nbeats) begin
            n_bad++;
            $display("FAIL r_count: beats=%0d required %0d (cycle budget spent)", i, nbeats);
        end
    endtask

    task automatic check_ar_log(input int n);
        logic [AW-1:0] a;
        n_cmp++;
        if (ar_log.size() != n) begin
            n_bad++;
            $display("FAIL lite_ar_count: issued=%0d required %0d", ar_log.size(), n);
        end
        for (int i = 0; i < ar_log.size(); i++) begin
            a = cur_addr + (AW'(i) << cur_size);
            n_cmp++;
            if (ar_log[i] !== a) begin
                n_bad++;
                $display("FAIL lite_ar_addr[%0d]: addr=%h required %h", i, ar_log[i], a);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctl: {ar_ready,r_valid,lite_ar_valid,lite_r_ready}=%b required 1000",
                     {nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready});
        end
        n_cmp++;
        if ({nasti_r_id, nasti_r_data, nasti_r_resp, lite_ar_addr, lite_ar_prot, lite_ar_qos} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: r_id=%h r_data=%h lite_ar_addr=%h prot=%h required all 0",
                     nasti_r_id, nasti_r_data, lite_ar_addr, lite_ar_prot);
        end
    endtask

    task automatic test_basic();
        nasti_ar_prot = 3'b101; nasti_ar_qos = 4'h6; nasti_ar_region = 4'h9; nasti_ar_user = 1'b1;
        start_burst(2'd1, 32'h0000_1000, 8'd3, 3'd2);
        n_cmp++;
        if ({nasti_ar_ready, lite_ar_valid, lite_ar_prot, lite_ar_qos, lite_ar_region, lite_ar_user}
            !== {1'b0, 1'b1, 3'b101, 4'h6, 4'h9, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_sideband: ar_ready=%b lite_valid=%b prot=%h qos=%h region=%h user=%b required 0 1 5 6 9 1",
                     nasti_ar_ready, lite_ar_valid, lite_ar_prot, lite_ar_qos, lite_ar_region, lite_ar_user);
        end
        collect(4, 0);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        n_cmp++;
        if ({nasti_ar_ready, nasti_r_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL basic_ready_back: {ar_ready,r_valid}=%b required 10", {nasti_ar_ready, nasti_r_valid});
        end
        check_ar_log(4);
        nasti_ar_prot = '0; nasti_ar_qos = '0; nasti_ar_region = '0; nasti_ar_user = '0;
    endtask

    task automatic test_len0();
        start_burst(2'd2, 32'h0000_0003, 8'd0, 3'd0);
        collect(1, 0);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        check_ar_log(1);
        n_cmp++;
        if (nasti_ar_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL len0_idle: ar_ready=%b required 1", nasti_ar_ready);
        end
    endtask

    task automatic test_backpressure();
        nasti_r_ready = 1'b0;
        start_burst(2'd3, 32'h0000_2000, 8'd7, 3'd2);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (ar_log.size() != BD) begin
            n_bad++;
            $display("FAIL bp_issued: lite_ars=%0d required %0d", ar_log.size(), BD);
        end
        n_cmp++;
        if ({nasti_r_valid, lite_ar_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_stall: {r_valid,lite_ar_valid}=%b required 10", {nasti_r_valid, lite_ar_valid});
        end
        collect(8, 0);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        check_ar_log(8);
    endtask

    task automatic test_resp_err();
        err_en = 1'b1;
        err_addr = 32'h0000_4004;
        start_burst(2'd0, 32'h0000_4000, 8'd3, 3'd2);
        collect(4, 0);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        n_cmp++;
        if (nasti_ar_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_complete: ar_ready=%b required 1", nasti_ar_ready);
        end
        err_en = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        start_burst(2'd1, 32'h0000_5000, 8'd3, 3'd2);
        collect(2, 0);
        @(posedge clk);
        #2;
        nasti_r_ready = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL midrst_ctl: {ar_ready,r_valid,lite_ar_valid,lite_r_ready}=%b required 1000",
                     {nasti_ar_ready, nasti_r_valid, lite_ar_valid, lite_r_ready});
        end
        start_burst(2'd2, 32'h0000_6000, 8'd1, 3'd2);
        collect(2, 0);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        check_ar_log(2);
    endtask

    task automatic test_long_wrap();
        slave_rand = 1'b1;
        start_burst(2'd3, 32'hFFFF_FF00, 8'd255, 3'd2);
        collect(256, 1);
        @(negedge clk);
        nasti_r_ready = 1'b0;
        slave_rand = 1'b0;
        check_ar_log(256);
        n_cmp++;
        if (ar_log.size() != 256 || ar_log[255] !== 32'h0000_02FC) begin
            n_bad++;
            $display("FAIL wrap_last_addr: count=%0d last=%h required 256 / 000002fc",
                     ar_log.size(), (ar_log.size() > 0) ? ar_log[ar_log.size()-1] : 32'h0);
        end
        n_cmp++;
        if (nasti_ar_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_done: ar_ready=%b required 1", nasti_ar_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_backpressure();
        test_resp_err();
        test_reset_mid_burst();
        test_long_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
